master_req_queue: RTL and testbench
===================================

// Module: master_req_queue
// PURPOSE
//  Request sequencer directly upstream of master_port. Buffers bus transactions (addr/mode/data)
//  from a local client in a DEPTH-entry FIFO and issues them one at a time on master_port's m_*
//  interface (m_start pulse), waits for completion and returns one response per request in order.
// PARAMETERS
//  DEPTH    4    request FIFO entries (power of 2, >=2)
//  ADDR_W   16   address width (matches m_addr)
//  DATA_W   8    data width (matches m_wr_data / m_rd_data)
//  TIMEOUT  255  completion watchdog, cycles (used only with MRQ_TIMEOUT_EN)
// PORTS
//  clk        in   1       system clock
//  rstn       in   1       asynchronous active-low reset
//  req_valid  in   1       client request valid
//  req_ready  out  1       FIFO can accept (high iff count<DEPTH)
//  req_addr   in   ADDR_W  target address (bit 15:12 select slave)
//  req_mode   in   1       1=write, 0=read
//  req_wdata  in   DATA_W  write data (ignored for reads)
//  rsp_valid  out  1       response valid, held until rsp_ready
//  rsp_ready  in   1       client accepts response
//  rsp_mode   out  1       mode of completed request
//  rsp_rdata  out  DATA_W  read data (0 for writes)
//  rsp_err    out  1       request aborted by watchdog
//  m_start    out  1       one-cycle start pulse to master_port
//  m_addr     out  ADDR_W  address to master_port, stable from m_start until m_done
//  m_wr_data  out  DATA_W  write data to master_port, stable as m_addr
//  m_mode     out  1       mode to master_port, stable as m_addr
//  m_rd_data  in   DATA_W  read data from master_port, valid when m_wr_en=1
//  m_wr_en    in   1       master_port read-data strobe
//  m_done     in   1       one-cycle transaction-complete pulse from master_port
// BEHAVIOUR
//  Reset (async, rstn=0): FIFO empty, FSM=IDLE; req_ready=1 after release; rsp_valid=0, rsp_mode=0,
//   rsp_rdata=0, rsp_err=0, m_start=0, m_addr=0, m_wr_data=0, m_mode=0. In-flight request and
//   buffered requests are discarded; no response generated.
//  FIFO: push on req_valid&req_ready; req_ready from registered count, so full blocks push even if
//   a pop occurs same cycle. Pointers wrap modulo DEPTH. Pop occurs in ISSUE.
//  FSM:
//   IDLE  : FIFO non-empty -> ISSUE.
//   ISSUE : pop head into m_addr/m_wr_data/m_mode, m_start=1 for exactly this cycle -> WAIT.
//   WAIT  : m_wr_en=1 -> capture m_rd_data into rd_hold. m_done=1 -> load rsp_* (rsp_rdata =
//           rd_hold, or m_rd_data if m_wr_en coincides with m_done; 0 if mode=1), rsp_valid=1 -> RESP.
//   RESP  : hold rsp_* stable; rsp_valid&rsp_ready -> rsp_valid=0 next cycle -> IDLE.
//  Latency: push at cycle N on empty idle queue -> m_start at N+2 (IDLE N+1, ISSUE N+2).
//   m_done at cycle M -> rsp_valid at M+1. Back-to-back: next m_start >=2 cycles after rsp handshake.
//  Only one transaction outstanding; responses strictly in request order.
//  m_done outside WAIT ignored. m_wr_en outside WAIT ignored. m_wr_en during a write ignored.
//  m_addr/m_wr_data/m_mode keep last issued values after completion (not cleared).
// CONFIGURATION
//  MRQ_TIMEOUT_EN defined: 8-bit-min watchdog counter cleared in ISSUE, increments each WAIT cycle;
//   reaching TIMEOUT without m_done -> rsp_err=1, rsp_rdata=0, go to RESP; a later stray m_done is
//   ignored. m_done on the same cycle as expiry wins (normal response, rsp_err=0).
//  MRQ_TIMEOUT_EN undefined: no counter; WAIT lasts until m_done; rsp_err tied 0.
// TESTING
//  1 Reset: rstn=0 mid-WAIT with 2 queued -> all outputs reset values, no rsp after release, req_ready=1.
//  2 Write: push addr=F234 mode=1 data=5A -> m_start 1-cycle pulse, m_addr=F234 m_wr_data=5A m_mode=1;
//    m_done -> rsp_valid, rsp_mode=1, rsp_rdata=00, rsp_err=0.
//  3 Read: push addr=F234 mode=0; model returns m_wr_en with m_rd_data=5A, then m_done ->
//    rsp_rdata=5A, rsp_mode=0; also case m_wr_en coincident with m_done -> rsp_rdata=5A.
//  4 Full/backpressure: push 5 with DEPTH=4, rsp_ready=0 -> req_ready=0 after 4 buffered
//    (first issued, so 5th accepted only after a pop); hold rsp_ready=0 10 cycles -> rsp stable,
//    no new m_start; release -> responses in push order.
//  5 Wrap: 10 sequential reads addr 1000..1009 -> 10 m_start pulses, addresses in order, pointers wrap.
//  6 MRQ_TIMEOUT_EN, TIMEOUT=20: never assert m_done -> rsp_err=1 exactly 20 WAIT cycles after m_start
//    cycle; stray m_done later ignored; next request proceeds normally.

Source files
------------

// File: rtl/master_req_queue.sv
// Request FIFO and sequencer that drives master_port, one transaction at a time.
// Optional completion watchdog: define MRQ_TIMEOUT_EN.
module master_req_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_mode,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_mode,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              m_start,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wr_data,
  output logic              m_mode,
  input  logic [DATA_W-1:0] m_rd_data,
  input  logic              m_wr_en,
  input  logic              m_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = ADDR_W + DATA_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1)
  begin : g_param_chk
    $error("master_req_queue: invalid DEPTH or TIMEOUT");
  end

  logic [1:0]        state;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              push;
  logic              pop;
  logic [ENT_W-1:0]  head;
  logic [DATA_W-1:0] rd_hold;
  logic              expire;

  assign req_ready = count < (PTR_W + 1)'(DEPTH);
  assign push      = req_valid & req_ready;
  assign pop       = (state == S_ISSUE);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {req_mode, req_wdata, req_addr};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef MRQ_TIMEOUT_EN
  localparam int CLG   = $clog2(TIMEOUT + 1);
  localparam int CNT_W = (CLG > 8) ? CLG : 8;

  logic [CNT_W-1:0] wdog;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      wdog <= '0;
    else if (state == S_ISSUE)
      wdog <= '0;
    else if (state == S_WAIT)
      wdog <= wdog + 1'b1;
  end

  // Fires on the last of TIMEOUT wait cycles; m_done wins on a tie.
  assign expire = (state == S_WAIT) && (wdog == CNT_W'(TIMEOUT - 1));
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      rsp_valid <= 1'b0;
      rsp_mode  <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      m_start   <= 1'b0;
      m_addr    <= '0;
      m_wr_data <= '0;
      m_mode    <= 1'b0;
      rd_hold   <= '0;
    end else begin
      m_start <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // Load the head a cycle early so m_addr is valid with m_start.
          if (count != '0) begin
            state     <= S_ISSUE;
            m_start   <= 1'b1;
            m_addr    <= head[ADDR_W-1:0];
            m_wr_data <= head[ADDR_W +: DATA_W];
            m_mode    <= head[ENT_W-1];
          end
        end
        S_ISSUE: begin
          rd_hold <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (m_done) begin
            rsp_valid <= 1'b1;
            rsp_mode  <= m_mode;
            rsp_err   <= 1'b0;
            if (m_mode)
              rsp_rdata <= '0;
            else if (m_wr_en)
              rsp_rdata <= m_rd_data;
            else
              rsp_rdata <= rd_hold;
            state <= S_RESP;
          end else if (expire) begin
            rsp_valid <= 1'b1;
            rsp_mode  <= m_mode;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= S_RESP;
          end else if (m_wr_en && !m_mode) begin
            rd_hold <= m_rd_data;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_master_req_queue.sv
// Directed bench for master_req_queue; models master_port by hand.
// Watchdog scenario runs only when MRQ_TIMEOUT_EN is defined.
module tb_master_req_queue;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 20;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              req_mode = 1'b0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic              rsp_mode;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              m_start;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wr_data;
  logic              m_mode;
  logic [DATA_W-1:0] m_rd_data = '0;
  logic              m_wr_en = 1'b0;
  logic              m_done = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  master_req_queue #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_mode(req_mode),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_mode(rsp_mode), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .m_start(m_start), .m_addr(m_addr),
    .m_wr_data(m_wr_data), .m_mode(m_mode),
    .m_rd_data(m_rd_data), .m_wr_en(m_wr_en),
    .m_done(m_done)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [15:0] a, input logic m,
                      input logic [7:0] d);
    int t = 0;
    while (!req_ready && t < 50) begin
      tick();
      t++;
    end
    if (!req_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL push_wait: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_mode  = m;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    int t = 0;
    while (!m_start && t < 30) begin
      tick();
      t++;
    end
    ok = m_start;
  endtask

  task automatic done(input logic we, input logic [7:0] rd);
    m_done    = 1'b1;
    m_wr_en   = we;
    m_rd_data = rd;
    tick();
    m_done  = 1'b0;
    m_wr_en = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [37:0] obs;
    logic [37:0] exp_v;
    bit bad;
    exp_v = {1'b1, 37'b0};
    rstn = 1'b0;
    repeat (2) tick();
    obs = {req_ready, rsp_valid, rsp_mode, rsp_err, m_start,
           m_mode, rsp_rdata, m_addr, m_wr_data};
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL reset_hold: got %h required %h", obs, exp_v);
    end
    rstn = 1'b1;
    tick();
    obs = {req_ready, rsp_valid, rsp_mode, rsp_err, m_start,
           m_mode, rsp_rdata, m_addr, m_wr_data};
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL reset_release: got %h required %h", obs, exp_v);
    end
    push(16'hA001, 1'b1, 8'h11);
    push(16'hA002, 1'b0, 8'h22);
    push(16'hA003, 1'b1, 8'h33);
    tick();
    #2 rstn = 1'b0;
    #1;
    obs = {req_ready, rsp_valid, rsp_mode, rsp_err, m_start,
           m_mode, rsp_rdata, m_addr, m_wr_data};
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL reset_mid_wait: got %h required %h", obs, exp_v);
    end
    tick();
    rstn = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_start || rsp_valid) bad = 1'b1;
    end
    n_chk++;
    if (bad !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_discard: activity=%b ready=%b required 0/1",
               bad, req_ready);
    end
  endtask

  task automatic test_write();
    push(16'hF234, 1'b1, 8'h5A);
    n_chk++;
    if (m_start !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_early_start: m_start=%b required 0", m_start);
    end
    tick();
    n_chk++;
    if ({m_start, m_addr, m_wr_data, m_mode} !== {1'b1, 16'hF234, 8'h5A, 1'b1}) begin
      n_fail++;
      $display("FAIL wr_issue: start=%b addr=%h data=%h mode=%b required 1/F234/5A/1",
               m_start, m_addr, m_wr_data, m_mode);
    end
    tick();
    n_chk++;
    if (m_start !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_pulse_width: m_start=%b required 0", m_start);
    end
    m_wr_en   = 1'b1;
    m_rd_data = 8'h33;
    tick();
    m_wr_en = 1'b0;
    done(1'b0, 8'h00);
    n_chk++;
    if ({rsp_valid, rsp_mode, rsp_rdata, rsp_err} !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL wr_rsp: valid=%b mode=%b rdata=%h err=%b required 1/1/00/0",
               rsp_valid, rsp_mode, rsp_rdata, rsp_err);
    end
    tick();
    n_chk++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_rsp_hold: rsp_valid=%b required 1", rsp_valid);
    end
    handshake();
    n_chk++;
    if (rsp_valid !== 1'b0 || m_addr !== 16'hF234) begin
      n_fail++;
      $display("FAIL wr_after_hs: valid=%b addr=%h required 0/F234",
               rsp_valid, m_addr);
    end
  endtask

  task automatic test_read();
    bit ok;
    push(16'hF234, 1'b0, 8'h00);
    wait_start(ok);
    n_chk++;
    if (!ok || m_mode !== 1'b0 || m_addr !== 16'hF234) begin
      n_fail++;
      $display("FAIL rd_issue: start=%b mode=%b addr=%h required 1/0/F234",
               ok, m_mode, m_addr);
    end
    tick();
    m_wr_en   = 1'b1;
    m_rd_data = 8'h5A;
    tick();
    m_wr_en   = 1'b0;
    m_rd_data = 8'hC3;
    repeat (2) tick();
    done(1'b0, 8'hC3);
    n_chk++;
    if ({rsp_valid, rsp_mode, rsp_rdata} !== {1'b1, 1'b0, 8'h5A}) begin
      n_fail++;
      $display("FAIL rd_held: valid=%b mode=%b rdata=%h required 1/0/5A",
               rsp_valid, rsp_mode, rsp_rdata);
    end
    handshake();
    push(16'hF234, 1'b0, 8'h00);
    wait_start(ok);
    tick();
    done(1'b1, 8'h5A);
    n_chk++;
    if (!ok || {rsp_valid, rsp_mode, rsp_rdata} !== {1'b1, 1'b0, 8'h5A}) begin
      n_fail++;
      $display("FAIL rd_coincident: start=%b valid=%b mode=%b rdata=%h required 1/1/0/5A",
               ok, rsp_valid, rsp_mode, rsp_rdata);
    end
    handshake();
    tick();
    done(1'b1, 8'h77);
    tick();
    n_chk++;
    if (rsp_valid !== 1'b0 || m_start !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_done_idle: valid=%b start=%b required 0/0",
               rsp_valid, m_start);
    end
  endtask

  task automatic test_full();
    bit ok;
    bit bad;
    for (int k = 0; k < 5; k++)
      push(16'h2001 + 16'(k), 1'b0, 8'h00);
    n_chk++;
    if (req_ready !== 1'b0 || m_addr !== 16'h2001) begin
      n_fail++;
      $display("FAIL full_ready: ready=%b addr=%h required 0/2001",
               req_ready, m_addr);
    end
    done(1'b1, 8'h01);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!rsp_valid || rsp_rdata !== 8'h01 || m_start || req_ready)
        bad = 1'b1;
    end
    n_chk++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL full_stall: unstable=%b required 0", bad);
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        wait_start(ok);
        n_chk++;
        if (!ok || m_addr !== 16'h2001 + 16'(k)) begin
          n_fail++;
          $display("FAIL full_order_addr%0d: start=%b addr=%h required 1/%h",
                   k, ok, m_addr, 16'h2001 + 16'(k));
        end
        tick();
        done(1'b1, 8'(k + 1));
      end
      n_chk++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 8'(k + 1)) begin
        n_fail++;
        $display("FAIL full_order_rsp%0d: valid=%b rdata=%h required 1/%h",
                 k, rsp_valid, rsp_rdata, 8'(k + 1));
      end
      handshake();
      n_chk++;
      if (m_start !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_gap%0d: m_start=%b required 0", k, m_start);
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int starts = 0;
    for (int i = 0; i < 10; i++) begin
      push(16'h1000 + 16'(i), 1'b0, 8'h00);
      wait_start(ok);
      if (ok) starts++;
      n_chk++;
      if (!ok || m_addr !== 16'h1000 + 16'(i)) begin
        n_fail++;
        $display("FAIL wrap_addr%0d: start=%b addr=%h required 1/%h",
                 i, ok, m_addr, 16'h1000 + 16'(i));
      end
      tick();
      done(1'b1, 8'h40 + 8'(i));
      n_chk++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h40 + 8'(i)) begin
        n_fail++;
        $display("FAIL wrap_rsp%0d: valid=%b rdata=%h required 1/%h",
                 i, rsp_valid, rsp_rdata, 8'h40 + 8'(i));
      end
      handshake();
    end
    n_chk++;
    if (starts !== 10) begin
      n_fail++;
      $display("FAIL wrap_starts: got %0d required 10", starts);
    end
  endtask

`ifdef MRQ_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int cnt;
    push(16'hB000, 1'b0, 8'h00);
    wait_start(ok);
    tick();
    m_wr_en   = 1'b1;
    m_rd_data = 8'hAA;
    tick();
    m_wr_en = 1'b0;
    cnt = 2;
    while (!rsp_valid && cnt < 60) begin
      tick();
      cnt++;
    end
    n_chk++;
    if (!ok || cnt !== TIMEOUT + 1 || rsp_err !== 1'b1 || rsp_rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL wdog_expire: cycles=%0d err=%b rdata=%h required %0d/1/00",
               cnt, rsp_err, rsp_rdata, TIMEOUT + 1);
    end
    handshake();
    tick();
    done(1'b1, 8'h99);
    tick();
    n_chk++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_stray_done: rsp_valid=%b required 0", rsp_valid);
    end
    push(16'hB001, 1'b0, 8'h00);
    wait_start(ok);
    tick();
    done(1'b1, 8'h3C);
    n_chk++;
    if (!ok || {rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 8'h3C}) begin
      n_fail++;
      $display("FAIL wdog_next: valid=%b err=%b rdata=%h required 1/0/3C",
               rsp_valid, rsp_err, rsp_rdata);
    end
    handshake();
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_full();
    test_wrap();
`ifdef MRQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
